// File: rtl/mips_defs.sv
// Shared MIPS encodings for the EX-stage multiply/divide unit: SPECIAL opcode,
// HI/LO-related function codes, sequencer states and the function decoder.
package mips_defs;

  localparam logic [5:0] OP_SPECIAL = 6'b000000;

  localparam logic [5:0] FUNC_MFHI  = 6'b010000;
  localparam logic [5:0] FUNC_MTHI  = 6'b010001;
  localparam logic [5:0] FUNC_MFLO  = 6'b010010;
  localparam logic [5:0] FUNC_MTLO  = 6'b010011;
  localparam logic [5:0] FUNC_MULT  = 6'b011000;
  localparam logic [5:0] FUNC_MULTU = 6'b011001;
  localparam logic [5:0] FUNC_DIV   = 6'b011010;
  localparam logic [5:0] FUNC_DIVU  = 6'b011011;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  typedef struct packed {
    logic valid;
    logic is_mul;
    logic is_div;
    logic is_signed;
    logic is_mfhi;
    logic is_mthi;
    logic is_mtlo;
  } dec_t;

  function automatic dec_t decode_func(input logic [5:0] func);
    dec_t d;
    d = '0;
    unique case (func)
      FUNC_MULT:  begin d.valid = 1'b1; d.is_mul = 1'b1; d.is_signed = 1'b1; end
      FUNC_MULTU: begin d.valid = 1'b1; d.is_mul = 1'b1; end
      FUNC_DIV:   begin d.valid = 1'b1; d.is_div = 1'b1; d.is_signed = 1'b1; end
      FUNC_DIVU:  begin d.valid = 1'b1; d.is_div = 1'b1; end
      FUNC_MFHI:  begin d.valid = 1'b1; d.is_mfhi = 1'b1; end
      FUNC_MFLO:  d.valid = 1'b1;
      FUNC_MTHI:  begin d.valid = 1'b1; d.is_mthi = 1'b1; end
      FUNC_MTLO:  begin d.valid = 1'b1; d.is_mtlo = 1'b1; end
      default:    d = '0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/muldiv_ctl_if.sv
// Pipeline <-> multiply/divide unit bundle: ID/EX instruction fields in,
// HI/LO state, move-from data and stall/busy status out.
interface muldiv_ctl_if #(
  parameter int XLEN = 32
);
  logic            ex_valid;
  logic [5:0]      op;
  logic [5:0]      func;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            flush;
  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;
  logic [XLEN-1:0] rdata;
  logic            busy;
  logic            stall;

  modport master (
    output ex_valid, op, func, a, b, flush,
    input  hi, lo, rdata, busy, stall
  );

  modport slave (
    input  ex_valid, op, func, a, b, flush,
    output hi, lo, rdata, busy, stall
  );
endinterface

// File: rtl/muldiv_iter.sv
// One iteration of the sequential datapath: a shift-add multiply step or a
// restoring-divide step over the {hi,lo} working pair. Purely combinational.
module muldiv_iter #(
  parameter int XLEN = 32
) (
  input  logic            is_div,
  input  logic [XLEN-1:0] hi_in,
  input  logic [XLEN-1:0] lo_in,
  input  logic [XLEN-1:0] opd,
  output logic [XLEN-1:0] hi_out,
  output logic [XLEN-1:0] lo_out
);

  logic [XLEN:0] sum;
  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;

  always_comb begin
    sum     = {1'b0, hi_in} + (lo_in[0] ? {1'b0, opd} : '0);
    shifted = {hi_in, lo_in[XLEN-1]};
    // Remainder stays below the divisor, so a wrapped (negative) difference
    // always shows up in the top bit.
    diff    = shifted - {1'b0, opd};
    if (is_div) begin
      hi_out = diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
      lo_out = {lo_in[XLEN-2:0], ~diff[XLEN]};
    end else begin
      hi_out = sum[XLEN:1];
      lo_out = {sum[0], lo_in[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_ctl.sv
// EX-stage multiply/divide sequencer owning HI/LO: one bit per cycle on
// magnitudes, sign fix-up at the end, stall for HI/LO users while busy.
module muldiv_ctl
  import mips_defs::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  muldiv_ctl_if.slave bus
);

  dec_t            dec;
  logic            special;
  logic            cmd;
  logic            cmd_md;
  logic            b_zero;

  state_t          state_reg;
  state_t          state_next;
  logic            busy;
  logic            stall;
  logic            start;
  logic            iterate;
  logic            fix_wr;
  logic            mt_hi;
  logic            mt_lo;

  logic [CNT_W-1:0] cnt_reg;
  logic [XLEN-1:0] hi_reg;
  logic [XLEN-1:0] lo_reg;
  logic [XLEN-1:0] wh_reg;
  logic [XLEN-1:0] wl_reg;
  logic [XLEN-1:0] opd_reg;
  logic            div_reg;
  logic            dz_reg;
  logic            neg_res_reg;
  logic            neg_rem_reg;

  logic            a_neg;
  logic            b_neg;
  logic [XLEN-1:0] a_abs;
  logic [XLEN-1:0] b_abs;
  logic [XLEN-1:0] iter_hi;
  logic [XLEN-1:0] iter_lo;
  logic [XLEN-1:0] fix_hi;
  logic [XLEN-1:0] fix_lo;
  logic [2*XLEN-1:0] prod;

  assign dec     = decode_func(bus.func);
  assign special = bus.ex_valid && (bus.op == OP_SPECIAL);
  assign cmd     = special && dec.valid && !bus.flush;
  assign cmd_md  = cmd && (dec.is_mul || dec.is_div);
  assign b_zero  = (bus.b == '0);

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= S_IDLE;
    else        state_reg <= state_next;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      S_IDLE: begin
        // A zero divisor needs no iterations; its result is fixed by definition.
        if (cmd_md) state_next = (dec.is_div && b_zero) ? S_FIX : S_RUN;
      end
      S_RUN: begin
        if (bus.flush)                   state_next = S_IDLE;
        else if (cnt_reg == CNT_W'(1))   state_next = S_FIX;
      end
      S_FIX:   state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    busy    = (state_reg != S_IDLE);
    stall   = busy && cmd;
    start   = cmd_md && !busy;
    iterate = (state_reg == S_RUN);
    fix_wr  = (state_reg == S_FIX) && !bus.flush;
    mt_hi   = cmd && dec.is_mthi && !busy;
    mt_lo   = cmd && dec.is_mtlo && !busy;
  end

  // ---------------- operand preparation ----------------
  always_comb begin
    a_neg = dec.is_signed && bus.a[XLEN-1];
    b_neg = dec.is_signed && bus.b[XLEN-1];
    a_abs = a_neg ? -bus.a : bus.a;
    b_abs = b_neg ? -bus.b : bus.b;
  end

  muldiv_iter #(.XLEN(XLEN)) u_iter (
    .is_div (div_reg),
    .hi_in  (wh_reg),
    .lo_in  (wl_reg),
    .opd    (opd_reg),
    .hi_out (iter_hi),
    .lo_out (iter_lo)
  );

  // ---------------- sign correction ----------------
  always_comb begin
    prod   = {wh_reg, wl_reg};
    fix_hi = wh_reg;
    fix_lo = wl_reg;
    if (dz_reg) begin
      fix_hi = wh_reg;
      fix_lo = wl_reg;
    end else if (div_reg) begin
      fix_lo = neg_res_reg ? -wl_reg : wl_reg;
      fix_hi = neg_rem_reg ? -wh_reg : wh_reg;
    end else if (neg_res_reg) begin
      {fix_hi, fix_lo} = -prod;
    end
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg     <= '0;
      hi_reg      <= '0;
      lo_reg      <= '0;
      wh_reg      <= '0;
      wl_reg      <= '0;
      opd_reg     <= '0;
      div_reg     <= 1'b0;
      dz_reg      <= 1'b0;
      neg_res_reg <= 1'b0;
      neg_rem_reg <= 1'b0;
    end else begin
      if (start) begin
        cnt_reg     <= CNT_W'(XLEN);
        div_reg     <= dec.is_div;
        dz_reg      <= dec.is_div && b_zero;
        neg_res_reg <= a_neg ^ b_neg;
        neg_rem_reg <= a_neg;
        if (dec.is_div && b_zero) begin
          // Raw dividend lands in HI, LO saturates to all ones.
          wh_reg  <= bus.a;
          wl_reg  <= '1;
          opd_reg <= '0;
        end else if (dec.is_div) begin
          wh_reg  <= '0;
          wl_reg  <= a_abs;
          opd_reg <= b_abs;
        end else begin
          wh_reg  <= '0;
          wl_reg  <= b_abs;
          opd_reg <= a_abs;
        end
      end else if (iterate) begin
        wh_reg  <= iter_hi;
        wl_reg  <= iter_lo;
        cnt_reg <= cnt_reg - CNT_W'(1);
      end

      if (fix_wr) begin
        hi_reg <= fix_hi;
        lo_reg <= fix_lo;
      end else begin
        if (mt_hi) hi_reg <= bus.a;
        if (mt_lo) lo_reg <= bus.a;
      end
    end
  end

  assign bus.hi    = hi_reg;
  assign bus.lo    = lo_reg;
  assign bus.rdata = (bus.op == OP_SPECIAL && dec.is_mfhi) ? hi_reg : lo_reg;
  assign bus.busy  = busy;
  assign bus.stall = stall;

endmodule

// File: tb/tb_muldiv_ctl.sv
// Bench for muldiv_ctl: directed cases plus random instruction stream,
// scoreboarded against an arithmetic HI/LO model.
module tb_muldiv_ctl;

  localparam int XLEN = 32;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_ADD   = 6'b100000;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
  } res_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  muldiv_ctl_if #(.XLEN(XLEN)) mif ();

  muldiv_ctl #(.XLEN(XLEN), .CNT_W(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (mif)
  );

  res_t        res_q[$];
  logic [31:0] rd_q[$];
  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic bit is_muldiv(input logic [5:0] f);
    return (f == F_MULT) || (f == F_MULTU) || (f == F_DIV) || (f == F_DIVU);
  endfunction

  // Architectural HI/LO effect of one instruction, straight from the ISA rules.
  task automatic model_apply(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    longint      p;
    logic [63:0] u;
    int          sa;
    int          sb;
    case (f)
      F_MULT: begin
        p = longint'($signed(a)) * longint'($signed(b));
        {m_hi, m_lo} = 64'(p);
      end
      F_MULTU: begin
        u = 64'(a) * 64'(b);
        {m_hi, m_lo} = u;
      end
      F_DIV, F_DIVU: begin
        if (b == 32'd0) begin
          m_lo = 32'hFFFF_FFFF;
          m_hi = a;
        end else if (f == F_DIV && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          m_lo = 32'h8000_0000;
          m_hi = 32'd0;
        end else if (f == F_DIV) begin
          sa = a;
          sb = b;
          m_lo = 32'(sa / sb);
          m_hi = 32'(sa % sb);
        end else begin
          m_lo = a / b;
          m_hi = a % b;
        end
      end
      F_MTHI: m_hi = a;
      F_MTLO: m_lo = a;
      default: ;
    endcase
  endtask

  task automatic bubble();
    mif.ex_valid = 1'b0;
    mif.op       = 6'd0;
    mif.func     = 6'd0;
    mif.a        = '0;
    mif.b        = '0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Present one instruction (entered at posedge+1) and hold it until the unit
  // stops stalling; returns the stall count and rdata seen on acceptance.
  task automatic issue(input logic [5:0] opc, input logic [5:0] f,
                       input logic [31:0] a, input logic [31:0] b, input bit apply,
                       output int nst, output logic [31:0] rd);
    mif.ex_valid = 1'b1;
    mif.op       = opc;
    mif.func     = f;
    mif.a        = a;
    mif.b        = b;
    if (opc == 6'd0 && f == F_MFHI) rd_q.push_back(m_hi);
    if (opc == 6'd0 && f == F_MFLO) rd_q.push_back(m_lo);
    nst = 0;
    forever begin
      @(negedge clk);
      if (!mif.stall) break;
      nst++;
      if (nst > 200) begin
        n_vec++;
        n_err++;
        $display("FAIL issue_timeout: func=%02h still stalled after %0d cycles, expected release", f, nst);
        break;
      end
    end
    rd = mif.rdata;
    if (apply && opc == 6'd0) begin
      model_apply(f, a, b);
      if (is_muldiv(f)) res_q.push_back('{m_hi, m_lo});
    end
    @(posedge clk);
    #1;
    bubble();
    $display("issue op=%02h func=%02h a=%08h b=%08h stalls=%0d", opc, f, a, b, nst);
  endtask

  task automatic wait_idle(output int nb);
    nb = 0;
    forever begin
      @(negedge clk);
      if (!mif.busy) break;
      nb++;
      if (nb > 200) begin
        n_vec++;
        n_err++;
        $display("FAIL busy_timeout: busy for %0d cycles, expected at most %0d", nb, XLEN + 1);
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rnd_opd();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  // Monitor: HI/LO checked whenever busy falls, rdata whenever a move-from is accepted.
  initial begin : monitor
    bit          busy_prev;
    res_t        r;
    logic [31:0] e;
    busy_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (busy_prev && !mif.busy) begin
        if (res_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_done: hi=0x%08h lo=0x%08h, expected no completion", mif.hi, mif.lo);
        end else begin
          r = res_q.pop_front();
          check("result_hi", mif.hi, r.hi);
          check("result_lo", mif.lo, r.lo);
        end
      end
      if (mif.ex_valid && mif.op == 6'd0 && (mif.func == F_MFHI || mif.func == F_MFLO) &&
          !mif.flush && !mif.stall) begin
        if (rd_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_read: rdata=0x%08h, expected no read", mif.rdata);
        end else begin
          e = rd_q.pop_front();
          check("rdata", mif.rdata, e);
        end
      end
      busy_prev = mif.busy;
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time exceeded, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int          nst;
    int          nb;
    logic [31:0] rd;
    logic [31:0] ra;
    logic [31:0] rb;
    logic [5:0]  fl[8];
    int          kind;

    fl = '{F_MULT, F_MULTU, F_DIV, F_DIVU, F_MTHI, F_MTLO, F_MFHI, F_MFLO};
    bubble();
    mif.flush = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    @(negedge clk);
    check("reset_hi", mif.hi, 32'd0);
    check("reset_lo", mif.lo, 32'd0);
    check("reset_busy", {31'd0, mif.busy}, 32'd0);
    check("reset_stall", {31'd0, mif.stall}, 32'd0);
    @(posedge clk);
    #1;

    // Moves while idle: single cycle, never stall.
    issue(6'd0, F_MTHI, 32'h1234, 32'd0, 1'b1, nst, rd);
    check("mthi_stall", 32'(nst), 32'd0);
    issue(6'd0, F_MFLO, 32'd0, 32'd0, 1'b1, nst, rd);
    check("mflo_stall", 32'(nst), 32'd0);
    check("mflo_data", rd, 32'd0);
    issue(6'd0, F_MFHI, 32'd0, 32'd0, 1'b1, nst, rd);
    check("mfhi_stall", 32'(nst), 32'd0);
    check("mfhi_data", rd, 32'h1234);

    issue(6'd0, F_MULTU, 32'hFFFF_FFFF, 32'd2, 1'b1, nst, rd);
    wait_idle(nb);
    check("multu_busy_cycles", 32'(nb), 32'(XLEN + 1));
    check("multu_hi", mif.hi, 32'h1);
    check("multu_lo", mif.lo, 32'hFFFF_FFFE);

    // mfhi presented two cycles after mult issue sees 32 stall cycles.
    issue(6'd0, F_MULT, 32'hFFFF_FFFD, 32'd7, 1'b1, nst, rd);
    idle_cycles(1);
    issue(6'd0, F_MFHI, 32'd0, 32'd0, 1'b1, nst, rd);
    check("mult_mfhi_stalls", 32'(nst), 32'd32);
    check("mult_mfhi_data", rd, 32'hFFFF_FFFF);
    check("mult_lo", mif.lo, 32'hFFFF_FFEB);

    issue(6'd0, F_DIV, 32'hFFFF_FFF9, 32'd2, 1'b1, nst, rd);
    wait_idle(nb);
    check("div_lo", mif.lo, 32'hFFFF_FFFD);
    check("div_hi", mif.hi, 32'hFFFF_FFFF);

    issue(6'd0, F_DIVU, 32'd7, 32'd0, 1'b1, nst, rd);
    wait_idle(nb);
    check("divu0_busy_cycles", 32'(nb), 32'd1);
    check("divu0_lo", mif.lo, 32'hFFFF_FFFF);
    check("divu0_hi", mif.hi, 32'd7);

    issue(6'd0, F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, nst, rd);
    wait_idle(nb);
    check("div_ovf_lo", mif.lo, 32'h8000_0000);
    check("div_ovf_hi", mif.hi, 32'd0);

    // Flush in RUN cycle 10: abort, HI/LO keep their values.
    issue(6'd0, F_DIV, 32'd100, 32'd7, 1'b0, nst, rd);
    idle_cycles(9);
    mif.flush = 1'b1;
    res_q.push_back('{m_hi, m_lo});
    @(posedge clk);
    #1 mif.flush = 1'b0;
    check("flush_busy", {31'd0, mif.busy}, 32'd0);
    check("flush_hi_kept", mif.hi, m_hi);
    check("flush_lo_kept", mif.lo, m_lo);

    // Independent instructions during RUN never stall; a second mult waits.
    ra = $urandom;
    rb = $urandom;
    issue(6'd0, F_MULT, ra, rb, 1'b1, nst, rd);
    for (int i = 0; i < 5; i++) begin
      mif.ex_valid = 1'b1;
      mif.op       = (i % 2 == 0) ? 6'd0 : 6'b100011;
      mif.func     = F_ADD;
      @(negedge clk);
      check("other_insn_stall", {31'd0, mif.stall}, 32'd0);
      @(posedge clk);
      #1 bubble();
    end
    issue(6'd0, F_MULT, $urandom, $urandom, 1'b1, nst, rd);
    check("second_mult_stalls", 32'(nst), 32'(XLEN + 1 - 5));
    wait_idle(nb);
    check("second_mult_busy", 32'(nb), 32'(XLEN + 1));

    // Async reset mid-RUN clears everything immediately.
    issue(6'd0, F_MULT, 32'd12345, 32'd678, 1'b1, nst, rd);
    idle_cycles(5);
    #2 rst_n = 1'b0;
    res_q.delete();
    res_q.push_back('{32'd0, 32'd0});
    m_hi = '0;
    m_lo = '0;
    #1;
    check("rst_busy", {31'd0, mif.busy}, 32'd0);
    check("rst_hi", mif.hi, 32'd0);
    check("rst_lo", mif.lo, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle_cycles(1);

    // Random instruction stream, back-to-back so HI/LO users often stall.
    for (int n = 0; n < 60; n++) begin
      kind = $urandom_range(0, 9);
      ra = rnd_opd();
      rb = rnd_opd();
      if (kind < 8)       issue(6'd0, fl[kind], ra, rb, 1'b1, nst, rd);
      else if (kind == 8) issue(6'($urandom_range(1, 63)), 6'($urandom_range(0, 63)), ra, rb, 1'b1, nst, rd);
      else                issue(6'd0, F_ADD, ra, rb, 1'b1, nst, rd);
      idle_cycles($urandom_range(0, 1));
    end
    wait_idle(nb);
    idle_cycles(2);
    check("res_queue_drained", 32'(res_q.size()), 32'd0);
    check("rd_queue_drained", 32'(rd_q.size()), 32'd0);
    check("final_hi", mif.hi, m_hi);
    check("final_lo", mif.lo, m_lo);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
